// File: rtl/pong_match_controller.sv
// Match sequencer for the pong pipeline: serve / rally / point / game-over phases,
// ball recentre and speed ramp, and both player scores. All timing is counted in frames.
module pong_match_controller #(
    parameter int SCORE_WIN     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int POINT_FRAMES  = 90,
    parameter int SPEED_BASE    = 4,
    parameter int SPEED_MAX     = 12,
    parameter int HITS_PER_STEP = 4
) (
    input  logic       pixIf_CLK,
    input  logic       rst,
    input  logic       pixIf_NEXT_FRAME,
    input  logic       startBtn,
    input  logic       paddleHit,
    input  logic       missLeft,
    input  logic       missRight,
    output logic       engineRun,
    output logic       engineRecenter,
    output logic       serveDir,
    output logic [3:0] ballSpeed,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner
);

    localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int HW        = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

    localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES);
    localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_STEP - 1);
    localparam logic [3:0]    WIN4       = 4'(SCORE_WIN);
    localparam logic [3:0]    BASE4      = 4'(SPEED_BASE);
    localparam logic [3:0]    MAX4       = 4'(SPEED_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [HW-1:0] hit_cnt_reg, hit_cnt_next;
    logic          start_prev_reg;
    logic [3:0]    score1_reg, score1_next;
    logic [3:0]    score2_reg, score2_next;
    logic [1:0]    winner_reg, winner_next;
    logic          serve_dir_reg, serve_dir_next;
    logic [3:0]    speed_reg, speed_next;
    logic          recenter_reg, recenter_next;

    logic          start_event;
    logic [FW-1:0] frame_inc;

    assign start_event = startBtn & ~start_prev_reg;
    assign frame_inc   = frame_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        hit_cnt_next   = hit_cnt_reg;
        score1_next    = score1_reg;
        score2_next    = score2_reg;
        winner_next    = winner_reg;
        serve_dir_next = serve_dir_reg;
        speed_next     = speed_reg;
        recenter_next  = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                if (start_event) begin
                    state_next     = SERVE;
                    score1_next    = 4'd0;
                    score2_next    = 4'd0;
                    winner_next    = 2'b00;
                    serve_dir_next = 1'b0;
                end
            end
            SERVE: begin
                if (pixIf_NEXT_FRAME) begin
                    frame_cnt_next = frame_inc;
                    if (frame_inc == SERVE_LAST) state_next = PLAY;
                end
            end
            PLAY: begin
                // A miss takes priority over a paddle hit in the same cycle.
                if (missLeft || missRight) begin
                    state_next = POINT;
                    if (missLeft && !missRight) begin
                        score2_next    = (score2_reg == 4'hF) ? 4'hF : score2_reg + 4'd1;
                        serve_dir_next = 1'b0;
                    end else if (missRight && !missLeft) begin
                        score1_next    = (score1_reg == 4'hF) ? 4'hF : score1_reg + 4'd1;
                        serve_dir_next = 1'b1;
                    end
                end else if (paddleHit) begin
                    if (hit_cnt_reg == HIT_LAST) begin
                        hit_cnt_next = '0;
                        speed_next   = (speed_reg < MAX4) ? speed_reg + 4'd1 : MAX4;
                    end else begin
                        hit_cnt_next = hit_cnt_reg + 1'b1;
                    end
                end
            end
            POINT: begin
                if (pixIf_NEXT_FRAME) begin
                    frame_cnt_next = frame_inc;
                    if (frame_inc == POINT_LAST) begin
                        if (score1_reg >= WIN4) begin
                            winner_next = 2'b01;
                            state_next  = OVER;
                        end else if (score2_reg >= WIN4) begin
                            winner_next = 2'b10;
                            state_next  = OVER;
                        end else begin
                            state_next = SERVE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Entry actions, applied on whichever edge changes the phase.
        if (state_next != state_reg) begin
            frame_cnt_next = '0;
            if (state_next == SERVE) begin
                recenter_next = 1'b1;
                speed_next    = BASE4;
                hit_cnt_next  = '0;
            end
        end
    end

    always_ff @(posedge pixIf_CLK) begin
        if (rst) begin
            state_reg      <= IDLE;
            frame_cnt_reg  <= '0;
            hit_cnt_reg    <= '0;
            start_prev_reg <= 1'b1;
            score1_reg     <= 4'd0;
            score2_reg     <= 4'd0;
            winner_reg     <= 2'b00;
            serve_dir_reg  <= 1'b0;
            speed_reg      <= BASE4;
            recenter_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            hit_cnt_reg    <= hit_cnt_next;
            start_prev_reg <= startBtn;
            score1_reg     <= score1_next;
            score2_reg     <= score2_next;
            winner_reg     <= winner_next;
            serve_dir_reg  <= serve_dir_next;
            speed_reg      <= speed_next;
            recenter_reg   <= recenter_next;
        end
    end

    assign engineRun      = (state_reg == PLAY);
    assign engineRecenter = recenter_reg;
    assign serveDir       = serve_dir_reg;
    assign ballSpeed      = speed_reg;
    assign score1         = score1_reg;
    assign score2         = score2_reg;
    assign winner         = winner_reg;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed scenarios plus a random run, all checked against
// a match-level reference model (frames remaining, total rally hits, scores).
module tb_pong_match_controller;

    localparam int WIN = 7, SF = 60, PF = 90, SB = 4, SM = 12, HPS = 4;
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nf = 1'b0, startBtn = 1'b0, paddleHit = 1'b0, missLeft = 1'b0, missRight = 1'b0;
    logic       engineRun, engineRecenter, serveDir;
    logic [3:0] ballSpeed, score1, score2;
    logic [1:0] winner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pong_match_controller #(
        .SCORE_WIN(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF),
        .SPEED_BASE(SB), .SPEED_MAX(SM), .HITS_PER_STEP(HPS)
    ) dut (
        .pixIf_CLK(clk), .rst(rst), .pixIf_NEXT_FRAME(nf), .startBtn(startBtn),
        .paddleHit(paddleHit), .missLeft(missLeft), .missRight(missRight),
        .engineRun(engineRun), .engineRecenter(engineRecenter), .serveDir(serveDir),
        .ballSpeed(ballSpeed), .score1(score1), .score2(score2), .winner(winner)
    );

    // Reference model: match phase, frames left in the current pause, hits this rally.
    int phase = P_IDLE, frames_left = 0, rally_hits = 0, s1 = 0, s2 = 0, win = 0;
    bit dir = 1'b0, rec = 1'b0, prev_btn = 1'b1;

    function automatic int exp_speed();
        int v = SB + rally_hits / HPS;
        return (v > SM) ? SM : v;
    endfunction

    function automatic logic [16:0] got_vec();
        return {engineRun, engineRecenter, serveDir, ballSpeed, score1, score2, winner};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {phase == P_PLAY, rec, dir, 4'(exp_speed()), 4'(s1), 4'(s2), 2'(win)};
    endfunction

    task automatic begin_serve();
        phase = P_SERVE; frames_left = SF; rally_hits = 0; rec = 1'b1;
    endtask

    task automatic new_game();
        s1 = 0; s2 = 0; win = 0; dir = 1'b0;
        begin_serve();
    endtask

    task automatic model_step(input bit r, input bit b, input bit f, input bit h,
                              input bit l, input bit rr);
        bit ev;
        ev = b && !prev_btn;
        prev_btn = b;
        rec = 1'b0;
        if (r) begin
            phase = P_IDLE; frames_left = 0; rally_hits = 0; s1 = 0; s2 = 0; win = 0;
            dir = 1'b0; prev_btn = 1'b1;
        end else begin
            case (phase)
                P_IDLE, P_OVER: if (ev) new_game();
                P_SERVE: if (f) begin
                    frames_left--;
                    if (frames_left == 0) phase = P_PLAY;
                end
                P_PLAY: begin
                    if (l || rr) begin
                        if (l && !rr) begin s2 = (s2 < 15) ? s2 + 1 : 15; dir = 1'b0; end
                        if (rr && !l) begin s1 = (s1 < 15) ? s1 + 1 : 15; dir = 1'b1; end
                        phase = P_POINT; frames_left = PF;
                    end else if (h) begin
                        rally_hits++;
                    end
                end
                P_POINT: if (f) begin
                    frames_left--;
                    if (frames_left == 0) begin
                        if (s1 >= WIN) begin win = 1; phase = P_OVER; end
                        else if (s2 >= WIN) begin win = 2; phase = P_OVER; end
                        else begin_serve();
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: apply frame/hit/miss inputs (rst and startBtn as currently set), update model.
    task automatic tick(input bit f, input bit h, input bit l, input bit rr);
        nf = f; paddleHit = h; missLeft = l; missRight = rr;
        @(posedge clk);
        #1;
        model_step(rst, startBtn, f, h, l, rr);
        nf = 1'b0; paddleHit = 1'b0; missLeft = 1'b0; missRight = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; startBtn = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (got_vec() !== {1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_state: got %h required %h", got_vec(), {1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'b00});
        end
        $display("reset: outputs %h", got_vec());
    endtask

    task automatic test_start_serve();
        startBtn = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (engineRecenter !== 1'b1 || engineRun !== 1'b0) begin
            n_bad++;
            $display("FAIL start_recenter: got rec=%b run=%b required rec=1 run=0", engineRecenter, engineRun);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (engineRecenter !== 1'b0) begin
            n_bad++;
            $display("FAIL recenter_width: got %b required 0", engineRecenter);
        end
        run_frames(SF - 1);
        n_cmp++;
        if (engineRun !== 1'b0) begin
            n_bad++;
            $display("FAIL serve_early: got run=%b required 0 after %0d frames", engineRun, SF - 1);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (engineRun !== 1'b1 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL serve_to_play: got run=%b vec=%h required run=1 vec=%h", engineRun, got_vec(), exp_vec());
        end
        $display("start: serve done, engineRun=%b", engineRun);
    endtask

    task automatic test_speed_ramp();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (ballSpeed !== 4'd5) begin
            n_bad++;
            $display("FAIL speed_step: got %0d required 5", ballSpeed);
        end
        for (int i = 0; i < 36; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ballSpeed !== 4'd12 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL speed_sat: got %0d vec=%h required 12 vec=%h", ballSpeed, got_vec(), exp_vec());
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (score1 !== 4'd1 || serveDir !== 1'b1 || engineRun !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_right: got s1=%0d dir=%b run=%b required s1=1 dir=1 run=0", score1, serveDir, engineRun);
        end
        run_frames(PF - 1);
        n_cmp++;
        if (engineRecenter !== 1'b0 || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL point_pause: got %h required %h", got_vec(), exp_vec());
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (engineRecenter !== 1'b1 || ballSpeed !== 4'd4) begin
            n_bad++;
            $display("FAIL reserve: got rec=%b speed=%0d required rec=1 speed=4", engineRecenter, ballSpeed);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        run_frames(SF);
        $display("speed ramp: point to p1, score %0d-%0d", score1, score2);
    endtask

    task automatic test_double_miss();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || engineRun !== 1'b0 || ballSpeed !== 4'd4
            || serveDir !== 1'b1) begin
            n_bad++;
            $display("FAIL double_miss: got s1=%0d s2=%0d run=%b speed=%0d dir=%b required 1 0 0 4 1",
                     score1, score2, engineRun, ballSpeed, serveDir);
        end
        run_frames(PF);
        run_frames(SF);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (ballSpeed !== 4'd4 || score2 !== 4'd1 || serveDir !== 1'b0
            || got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL hit_with_miss: got speed=%0d s2=%0d dir=%b vec=%h required 4 1 0 vec=%h",
                     ballSpeed, score2, serveDir, got_vec(), exp_vec());
        end
        $display("double miss: score %0d-%0d", score1, score2);
    endtask

    task automatic test_hold_start_reset();
        rst = 1'b1; startBtn = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (engineRecenter !== 1'b0 || got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL held_start: got %h required %h", got_vec(), exp_vec());
            end
        end
        startBtn = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        startBtn = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (engineRecenter !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_edge: got rec=%b required 1", engineRecenter);
        end
        run_frames(SF);
        $display("held start: game begins on fresh edge, run=%b", engineRun);
    endtask

    task automatic test_win();
        for (int p = 1; p <= WIN; p++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (p < WIN) begin
                run_frames(PF);
                run_frames(SF);
            end
            $display("win: p1 point %0d", p);
        end
        run_frames(PF);
        n_cmp++;
        if (winner !== 2'b01 || engineRun !== 1'b0 || score1 !== 4'd7) begin
            n_bad++;
            $display("FAIL game_over: got winner=%b run=%b s1=%0d required 01 0 7", winner, engineRun, score1);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (got_vec() !== exp_vec() || score2 !== 4'd0) begin
            n_bad++;
            $display("FAIL over_ignores: got %h required %h", got_vec(), exp_vec());
        end
        startBtn = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        startBtn = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (score1 !== 4'd0 || winner !== 2'b00 || engineRecenter !== 1'b1 || serveDir !== 1'b0) begin
            n_bad++;
            $display("FAIL new_game: got s1=%0d win=%b rec=%b dir=%b required 0 00 1 0",
                     score1, winner, engineRecenter, serveDir);
        end
    endtask

    task automatic test_random();
        int s1_seen, s2_seen;
        for (int c = 0; c < 20000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 29) == 0) startBtn = ~startBtn;
            s1_seen = s1; s2_seen = s2;
            tick($urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_c%0d: got %h required %h", c, got_vec(), exp_vec());
            end
            if (s1 != s1_seen || s2 != s2_seen)
                $display("random: cycle %0d score %0d-%0d winner %0d", c, s1, s2, win);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_speed_ramp();
        test_double_miss();
        test_hold_start_reset();
        test_win();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
